// File: rtl/pn_sched_pkg.sv
// Shared types and constants for the PN burst scheduler: FSM states,
// default LFSR polynomial/seed and a one-hot helper for grant vectors.
package pn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [3:0] DEF_TAPS = 4'b1001;  // x^4 + x^3 + 1
  localparam logic [3:0] DEF_SEED = 4'b0001;
  localparam int         MAX_NREQ = 32;

  function automatic logic [MAX_NREQ-1:0] onehot(input int unsigned idx);
    onehot = {{(MAX_NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/pn_lfsr_core.sv
// Fibonacci LFSR with seed load and all-zero lockup recovery.
// Lockup recovery outranks both load and advance.
module pn_lfsr_core
  import pn_sched_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  logic fb;

  assign fb   = ^(q & TAPS);
  assign zero = (q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset)    q <= SEED;
    else if (zero) q <= SEED;
    else if (load) q <= load_val;
    else if (adv)  q <= {q[WIDTH-2:0], fb};
  end

endmodule

// File: rtl/pn_burst_sched.sv
// Round-robin arbiter handing serial bursts from one shared PN stream to
// NREQ requesters; the LFSR state carries over from burst to burst.
module pn_burst_sched
  import pn_sched_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED),
  parameter int               NREQ  = 4,
  parameter int               LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  input  logic                  seed_load,
  input  logic [WIDTH-1:0]      seed_val,
  output logic [NREQ-1:0]       gnt,
  output logic                  pn_bit,
  output logic                  pn_valid,
  output logic                  pn_last,
  output logic                  busy,
  output logic                  err_lockup
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              state, state_n;
  logic [NREQ-1:0]     gnt_n;
  logic [LEN_W-1:0]    cnt, cnt_n;
  logic [PTR_W-1:0]    rr_ptr, rr_n;
  logic [PTR_W-1:0]    winner;
  logic                found;
  logic [MAX_NREQ-1:0] win_oh;
  logic [WIDTH-1:0]    lfsr;
  logic                zero;
  logic                held;

  pn_lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .adv      (pn_valid),
    .load     (seed_load && (state == IDLE)),
    .load_val (seed_val),
    .q        (lfsr),
    .zero     (zero)
  );

  // Circular search for the first request at or after rr_ptr.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr;
    for (int off = 0; off < NREQ; off++) begin
      if (!found && req[(int'(rr_ptr) + off) % NREQ]) begin
        found  = 1'b1;
        winner = PTR_W'((int'(rr_ptr) + off) % NREQ);
      end
    end
    win_oh = onehot(32'(winner));
  end

  // A dropped grant aborts the burst before any bit goes out that cycle.
  assign held       = |(req & gnt);
  assign pn_valid   = (state == RUN) && held && !zero;
  assign pn_last    = pn_valid && (cnt == LEN_W'(1));
  assign pn_bit     = lfsr[WIDTH-1];
  assign busy       = (state != IDLE);
  assign err_lockup = zero;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (!seed_load && found) begin
          gnt_n   = win_oh[NREQ-1:0];
          cnt_n   = len[int'(winner)*LEN_W +: LEN_W];
          rr_n    = (winner == PTR_W'(NREQ-1)) ? '0 : winner + 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (!held) begin
          gnt_n   = '0;
          state_n = GAP;
        end else if (pn_valid) begin
          cnt_n = cnt - 1'b1;
          if (pn_last) begin
            gnt_n   = '0;
            state_n = GAP;
          end
        end
      end
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      gnt    <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_n;
      gnt    <= gnt_n;
      cnt    <= cnt_n;
      rr_ptr <= rr_n;
    end
  end

endmodule

// File: tb/tb_pn_burst_sched.sv
// Self-checking bench for pn_burst_sched: directed scenarios followed by
// randomized bursts, aborts and seed loads against a transaction-level model.
module tb_pn_burst_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] len;
  logic        seed_load;
  logic [3:0]  seed_val;
  logic [3:0]  gnt;
  logic        pn_bit, pn_valid, pn_last, busy, err_lockup;

  pn_burst_sched dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .len        (len),
    .seed_load  (seed_load),
    .seed_val   (seed_val),
    .gnt        (gnt),
    .pn_bit     (pn_bit),
    .pn_valid   (pn_valid),
    .pn_last    (pn_last),
    .busy       (busy),
    .err_lockup (err_lockup)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: PN state as an integer plus the round-robin pointer.
  int   m_lfsr;
  int   m_rr;
  int   lens [4];
  logic bits [256];
  logic b1   [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pn_step(input int s);
    return ((s << 1) & 15) | (((s >> 3) ^ s) & 1);
  endfunction

  function automatic logic m_bit();
    return logic'((m_lfsr >> 3) & 1);
  endfunction

  function automatic int pick(input logic [3:0] m, input int rr);
    for (int off = 0; off < 4; off++)
      if (m[(rr + off) % 4]) return (rr + off) % 4;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_len();
    for (int i = 0; i < 4; i++) len[i*8 +: 8] = 8'(lens[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   32'(gnt),        0);
    check({tag, "_valid"}, 32'(pn_valid),   0);
    check({tag, "_last"},  32'(pn_last),    0);
    check({tag, "_busy"},  32'(busy),       0);
    check({tag, "_err"},   32'(err_lockup), 0);
    check({tag, "_bit"},   32'(pn_bit),     0);
  endtask

  task automatic do_reset();
    req = '0; seed_load = 1'b0; reset = 1'b0;
    tick();
    check_all_zero("reset");
    reset = 1'b1;
    m_lfsr = 1; m_rr = 0;
  endtask

  // One arbitration + burst; abort_at >= 0 drops the grant before that bit.
  task automatic do_burst(input logic [3:0] mask, input int abort_at, input bit chaos);
    int w, l;
    bit aborted;
    aborted = 1'b0;
    check("pre_idle", 32'(busy), 0);
    req = mask;
    drive_len();
    tick();
    w = pick(mask, m_rr);
    l = (lens[w] == 0) ? 256 : lens[w];
    m_rr = (w + 1) % 4;
    check("gnt", 32'(gnt), 32'(1) << w);
    for (int i = 0; i < l; i++) begin
      if (i == abort_at) begin
        req = mask & ~(4'(1) << w);
        #1;
        check("abort_valid", 32'(pn_valid), 0);
        check("abort_last",  32'(pn_last),  0);
        aborted = 1'b1;
        break;
      end
      check("valid",    32'(pn_valid), 1);
      check("bit",      32'(pn_bit),   32'(m_bit()));
      check("last",     32'(pn_last),  32'(i == l - 1));
      check("gnt_hold", 32'(gnt),      32'(1) << w);
      bits[i] = pn_bit;
      m_lfsr  = pn_step(m_lfsr);
      if (chaos) begin
        seed_load = ($urandom % 6) == 0;
        seed_val  = 4'($urandom);
        len       = $urandom;
      end
      tick();
    end
    if (aborted) tick();
    check("gap_valid", 32'(pn_valid), 0);
    check("gap_gnt",   32'(gnt),      0);
    check("gap_busy",  32'(busy),     1);
    req = '0; seed_load = 1'b0;
    tick();
    check("post_idle", 32'(busy), 0);
  endtask

  // Seed load in IDLE; requests offered in the same cycle must not be granted.
  task automatic seed_op(input logic [3:0] v, input logic [3:0] mask);
    seed_load = 1'b1; seed_val = v; req = mask;
    tick();
    seed_load = 1'b0; req = '0;
    m_lfsr = int'(v);
    check("seed_nognt", 32'(gnt),        0);
    check("seed_busy",  32'(busy),       0);
    check("seed_err",   32'(err_lockup), 32'(v == 4'd0));
    check("seed_bit",   32'(pn_bit),     32'(m_bit()));
    if (v == 4'd0) begin
      tick();
      m_lfsr = 1;
      check("lockup_clr", 32'(err_lockup), 0);
      check("lockup_bit", 32'(pn_bit),     32'(m_bit()));
    end
  endtask

  initial begin
    logic [7:0] exp8;
    logic [3:0] mask, sv;
    reset = 1'b0; req = '0; len = '0; seed_load = 1'b0; seed_val = '0;
    lens = '{8, 2, 2, 2};
    @(negedge clk);
    do_reset();

    // Known first 8 bits of the stream from seed 0001.
    do_burst(4'b0001, -1, 1'b0);
    exp8 = 8'b0001_1110;
    for (int i = 0; i < 8; i++) check("seq8", 32'(bits[i]), 32'(exp8[7-i]));

    // All four requesting with len=2: grants rotate every 4 cycles.
    do_reset();
    lens = '{2, 2, 2, 2};
    drive_len();
    req = 4'hF;
    tick();
    for (int c = 0; c < 20; c++) begin
      check("rr_gnt",   32'(gnt),      (c % 4 < 2) ? (32'(1) << ((c / 4) % 4)) : 32'd0);
      check("rr_valid", 32'(pn_valid), 32'(c % 4 < 2));
      if (pn_valid) begin
        check("rr_bit", 32'(pn_bit), 32'(m_bit()));
        m_lfsr = pn_step(m_lfsr);
      end
      if (c == 19) req = '0;
      tick();
    end
    m_rr = 1;
    check("rr_idle", 32'(busy), 0);

    // len=0 -> 256-bit burst.
    lens[1] = 0;
    do_burst(4'b0010, -1, 1'b0);

    // Abort after 2 bits, then the stream resumes at bit 3.
    lens[2] = 5;
    do_burst(4'b0100, 2, 1'b0);
    do_burst(4'b0100, -1, 1'b0);

    // Zero seed triggers lockup recovery; seed loads during RUN are ignored.
    seed_op(4'd0, 4'b1111);
    seed_op(4'b1010, 4'b0011);
    lens = '{9, 9, 9, 9};
    do_burst(4'b1001, -1, 1'b1);

    // Two 15-bit bursts cover two full periods of the sequence.
    do_reset();
    lens[3] = 15;
    do_burst(4'b1000, -1, 1'b0);
    for (int i = 0; i < 15; i++) b1[i] = bits[i];
    do_burst(4'b1000, -1, 1'b0);
    for (int i = 0; i < 15; i++) check("period", 32'(bits[i]), 32'(b1[i]));

    // Reset in the middle of a burst.
    drive_len();
    req = 4'b1000;
    tick();
    tick();
    tick();
    check("mid_busy", 32'(busy), 1);
    reset = 1'b0;
    tick();
    check_all_zero("midrst");
    req = '0; reset = 1'b1;
    m_lfsr = 1; m_rr = 0;
    tick();

    // Randomized mix of bursts, aborts and seed loads.
    for (int n = 0; n < 40; n++) begin
      if ($urandom % 5 == 0) begin
        sv   = ($urandom % 4 == 0) ? 4'd0 : 4'($urandom);
        mask = 4'($urandom);
        seed_op(sv, mask);
        tick();
      end else begin
        mask = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++)
          lens[i] = ($urandom % 16 == 0) ? 0 : $urandom_range(1, 12);
        do_burst(mask, ($urandom % 4 == 0) ? $urandom_range(0, 11) : -1, 1'($urandom % 2));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
